// File: rtl/overture_pkg.sv
// rtl/overture_pkg.sv - shared opcode, ALU and condition encodings for the Overture core
// Purpose: type definitions and field constants used by the core and its ALU.
// Ports: none (package).
package overture_pkg;

  typedef enum logic [1:0] {
    OP_IMM  = 2'd0,
    OP_ALU  = 2'd1,
    OP_COPY = 2'd2,
    OP_COND = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_OR   = 3'd0,
    ALU_NAND = 3'd1,
    ALU_NOR  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_ADD  = 3'd4,
    ALU_SUB  = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_SHL  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    COND_NEVER  = 3'd0,
    COND_EQZ    = 3'd1,
    COND_LTZ    = 3'd2,
    COND_LEZ    = 3'd3,
    COND_ALWAYS = 3'd4,
    COND_NEZ    = 3'd5,
    COND_GEZ    = 3'd6,
    COND_GTZ    = 3'd7
  } cond_e;

  localparam int          NUM_REGS = 6;
  localparam logic [2:0]  SRC_IO   = 3'd6;
  localparam logic [2:0]  DST_IO   = 3'd6;
  localparam logic [2:0]  SRC_ZERO = 3'd7;
  localparam logic [2:0]  DST_NULL = 3'd7;

endpackage

// File: rtl/overture_alu.sv
// rtl/overture_alu.sv - combinational ALU for the Overture core
// Purpose: computes f(a, b) for the eight ALU function codes, modulo 2^DATA_W.
// Ports: i_a (r1), i_b (r2), i_op (function code), o_y (result).
module overture_alu
  import overture_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (alu_op_e'(i_op))
      ALU_OR:   o_y = i_a | i_b;
      ALU_NAND: o_y = ~(i_a & i_b);
      ALU_NOR:  o_y = ~(i_a | i_b);
      ALU_AND:  o_y = i_a & i_b;
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SHL:  o_y = {i_a[DATA_W-2:0], 1'b0};
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/overture_cpu_param.sv
// rtl/overture_cpu_param.sv - parametrised Overture core with loadable program RAM
// Purpose: single-cycle Overture core; decode, register file, PC, input/output
//   handshake, retired counter and program RAM.
// Ports: clk, reset_n (async active-low), run/step (execute controls),
//   prog_we/prog_addr/prog_data (RAM load while halted), in_port/in_valid/in_ready
//   (input handshake), out_port/out_valid (output), pc, instr_debug, stalled,
//   retired, r0_out..r5_out (register file view).
module overture_cpu_param
  import overture_pkg::*;
#(
  parameter int    DATA_W     = 8,
  parameter int    PROG_DEPTH = 256,
  parameter string PROG_FILE  = "",
  localparam int   PC_W       = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              step,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [7:0]        prog_data,
  input  logic [DATA_W-1:0] in_port,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic [PC_W-1:0]   pc,
  output logic [7:0]        instr_debug,
  output logic              stalled,
  output logic [31:0]       retired,
  output logic [DATA_W-1:0] r0_out,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  output logic [DATA_W-1:0] r3_out,
  output logic [DATA_W-1:0] r4_out,
  output logic [DATA_W-1:0] r5_out
);

  logic [7:0]        r_ram [PROG_DEPTH];
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_out_port;
  logic              r_out_valid;
  logic [31:0]       r_retired;

  logic [7:0]        w_instr;
  opcode_e           w_opcode;
  logic [2:0]        w_src;
  logic [2:0]        w_dst;
  logic              w_exec;
  logic              w_wants_in;
  logic              w_stall;
  logic              w_complete;
  logic [DATA_W-1:0] w_src_val;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_r3_neg;
  logic              w_r3_zero;
  logic              w_taken;
  logic [PC_W-1:0]   w_pc_next;

  // Loads are only honoured while the core is fully halted.
  always_ff @(posedge clk) begin
    if (prog_we && !w_exec) r_ram[prog_addr] <= prog_data;
  end

  assign w_instr    = r_ram[r_pc];
  assign w_opcode   = opcode_e'(w_instr[7:6]);
  assign w_src      = w_instr[5:3];
  assign w_dst      = w_instr[2:0];
  assign w_exec     = run | step;
  assign w_wants_in = (w_opcode == OP_COPY) && (w_src == SRC_IO);
  assign w_stall    = w_exec && w_wants_in && !in_valid;
  assign w_complete = w_exec && !w_stall;

  always_comb begin
    w_src_val = '0;
    if (w_src == SRC_IO) begin
      w_src_val = in_port;
    end else if (w_src != SRC_ZERO) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_src == 3'(i)) w_src_val = r_regs[i];
      end
    end
  end

  overture_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a  (r_regs[1]),
    .i_b  (r_regs[2]),
    .i_op (w_instr[2:0]),
    .o_y  (w_alu_y)
  );

  // Conditions look at r3 as a signed DATA_W value.
  assign w_r3_neg  = r_regs[3][DATA_W-1];
  assign w_r3_zero = (r_regs[3] == '0);

  always_comb begin
    w_taken = 1'b0;
    case (cond_e'(w_instr[2:0]))
      COND_NEVER:  w_taken = 1'b0;
      COND_EQZ:    w_taken = w_r3_zero;
      COND_LTZ:    w_taken = w_r3_neg;
      COND_LEZ:    w_taken = w_r3_neg | w_r3_zero;
      COND_ALWAYS: w_taken = 1'b1;
      COND_NEZ:    w_taken = !w_r3_zero;
      COND_GEZ:    w_taken = !w_r3_neg;
      COND_GTZ:    w_taken = !w_r3_neg && !w_r3_zero;
      default:     w_taken = 1'b0;
    endcase
  end

  // PC_W-wide increment wraps PROG_DEPTH-1 -> 0 since the depth is a power of 2.
  assign w_pc_next = ((w_opcode == OP_COND) && w_taken) ? r_regs[0][PC_W-1:0]
                                                        : r_pc + PC_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= '0;
      r_out_port  <= '0;
      r_out_valid <= 1'b0;
      r_retired   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_complete) begin
        r_pc      <= w_pc_next;
        r_retired <= r_retired + 32'd1;
        case (w_opcode)
          OP_IMM: r_regs[0] <= {{(DATA_W-6){1'b0}}, w_instr[5:0]};
          OP_ALU: r_regs[3] <= w_alu_y;
          OP_COPY: begin
            if (w_dst == DST_IO) begin
              r_out_port  <= w_src_val;
              r_out_valid <= 1'b1;
            end else if (w_dst != DST_NULL) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (w_dst == 3'(i)) r_regs[i] <= w_src_val;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready    = w_exec && w_wants_in && in_valid;
  assign stalled     = w_stall;
  assign out_port    = r_out_port;
  assign out_valid   = r_out_valid;
  assign pc          = r_pc;
  assign instr_debug = w_instr;
  assign retired     = r_retired;
  assign r0_out      = r_regs[0];
  assign r1_out      = r_regs[1];
  assign r2_out      = r_regs[2];
  assign r3_out      = r_regs[3];
  assign r4_out      = r_regs[4];
  assign r5_out      = r_regs[5];

endmodule

// File: tb/tb_overture_cpu_param.sv
// tb/tb_overture_cpu_param.sv - self-checking bench for overture_cpu_param
module tb_overture_cpu_param;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int PW    = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0, step = 1'b0, prog_we = 1'b0, in_valid = 1'b0;
  logic [PW-1:0] prog_addr = '0;
  logic [7:0]    prog_data = '0;
  logic [DW-1:0] in_port = '0;
  logic          in_ready, out_valid, stalled;
  logic [DW-1:0] out_port, r0_out, r1_out, r2_out, r3_out, r4_out, r5_out;
  logic [PW-1:0] pc;
  logic [7:0]    instr_debug;
  logic [31:0]   retired;

  overture_cpu_param #(.DATA_W(DW), .PROG_DEPTH(DEPTH), .PROG_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_port(in_port), .in_valid(in_valid), .in_ready(in_ready),
    .out_port(out_port), .out_valid(out_valid), .pc(pc),
    .instr_debug(instr_debug), .stalled(stalled), .retired(retired),
    .r0_out(r0_out), .r1_out(r1_out), .r2_out(r2_out),
    .r3_out(r3_out), .r4_out(r4_out), .r5_out(r5_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state only.
  logic [7:0]  m_mem [DEPTH];
  logic [DW-1:0] m_r [6];
  int          m_pc;
  logic [DW-1:0] m_out;
  bit          m_ov;
  logic [31:0] m_ret;
  bit          m_chk = 0;

  function automatic logic [DW-1:0] m_alu(input int f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (f)
      0: return a | b;
      1: return ~(a & b);
      2: return ~(a | b);
      3: return a & b;
      4: return a + b;
      5: return a - b;
      6: return a ^ b;
      default: return a << 1;
    endcase
  endfunction

  function automatic bit m_cond(input int c, input logic [DW-1:0] v);
    logic signed [DW-1:0] s;
    s = v;
    case (c)
      0: return 0;
      1: return s == 0;
      2: return s < 0;
      3: return s <= 0;
      4: return 1;
      5: return s != 0;
      6: return s >= 0;
      default: return s > 0;
    endcase
  endfunction

  function automatic bit m_wants_in();
    logic [7:0] ins;
    ins = m_mem[m_pc];
    return (ins[7:6] == 2'b10) && (ins[5:3] == 3'd6);
  endfunction

  always @(posedge clk) begin
    if (prog_we && !(run || step)) m_mem[prog_addr] = prog_data;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 0; m_out = '0; m_ov = 0; m_ret = '0;
      for (int i = 0; i < 6; i++) m_r[i] = '0;
    end else begin
      logic [7:0] ins;
      logic [DW-1:0] v;
      int s, d, npc;
      bit ov;
      ov = 0;
      ins = m_mem[m_pc];
      s = int'(ins[5:3]);
      d = int'(ins[2:0]);
      if ((run || step) && !(m_wants_in() && !in_valid)) begin
        npc = (m_pc + 1) % DEPTH;
        case (ins[7:6])
          2'b00: m_r[0] = DW'(ins[5:0]);
          2'b01: m_r[3] = m_alu(d, m_r[1], m_r[2]);
          2'b10: begin
            v = (s < 6) ? m_r[s] : (s == 6) ? in_port : '0;
            if (d < 6) m_r[d] = v;
            else if (d == 6) begin m_out = v; ov = 1; end
          end
          default: if (m_cond(d, m_r[3])) npc = int'(m_r[0]) % DEPTH;
        endcase
        m_pc = npc;
        m_ret = m_ret + 1;
      end
      m_ov = ov;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  int ov_cnt = 0, ir_cnt = 0;
  always @(negedge clk) begin
    if (out_valid) ov_cnt++;
    if (in_ready) ir_cnt++;
    if (m_chk && reset_n) begin
      bit ex, win;
      ex  = run || step;
      win = m_wants_in();
      chk("pc", 32'(pc), 32'(m_pc));
      chk("instr_debug", 32'(instr_debug), 32'(m_mem[m_pc]));
      chk("r0", 32'(r0_out), 32'(m_r[0]));
      chk("r1", 32'(r1_out), 32'(m_r[1]));
      chk("r2", 32'(r2_out), 32'(m_r[2]));
      chk("r3", 32'(r3_out), 32'(m_r[3]));
      chk("r4", 32'(r4_out), 32'(m_r[4]));
      chk("r5", 32'(r5_out), 32'(m_r[5]));
      chk("out_port", 32'(out_port), 32'(m_out));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("retired", retired, m_ret);
      chk("in_ready", 32'(in_ready), 32'(ex && win && in_valid));
      chk("stalled", 32'(stalled), 32'(ex && win && !in_valid));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = PW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  logic [7:0] prog2 [6];
  logic [7:0] prog4 [7];

  initial begin
    prog2 = '{8'h05, 8'h81, 8'h02, 8'h82, 8'h44, 8'h9E};
    prog4 = '{8'h41, 8'h99, 8'h01, 8'h82, 8'h44, 8'h10, 8'hC1};
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) load(i, 8'h87);
    for (int i = 0; i < 6; i++) load(i, prog2[i]);
    m_chk = 1;

    // reset state
    chk("rst_pc", 32'(pc), 0);
    chk("rst_retired", retired, 0);
    chk("rst_out", 32'(out_port), 0);
    chk("rst_r0", 32'(r0_out), 0);

    // straight-line program with one output
    ov_cnt = 0;
    run = 1'b1;
    tick(6);
    run = 1'b0;
    chk("t2_r1", 32'(r1_out), 5);
    chk("t2_r2", 32'(r2_out), 2);
    chk("t2_r3", 32'(r3_out), 7);
    chk("t2_out", 32'(out_port), 7);
    chk("t2_ov", 32'(out_valid), 1);
    chk("t2_retired", retired, 6);
    tick();
    chk("t2_ov_pulses", 32'(ov_cnt), 1);

    // async reset in the middle of a running cycle
    run = 1'b1;
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_pc", 32'(pc), 0);
    chk("t1_retired", retired, 0);
    chk("t1_out", 32'(out_port), 0);
    chk("t1_ov", 32'(out_valid), 0);
    chk("t1_r1", 32'(r1_out), 0);
    chk("t1_r3", 32'(r3_out), 0);
    run = 1'b0;
    tick();
    reset_n = 1'b1;

    // input stall then accept
    load(0, 8'hB0);
    ir_cnt = 0;
    in_valid = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_stalled", 32'(stalled), 1);
      chk("t3_pc", 32'(pc), 0);
      tick();
    end
    in_valid = 1'b1; in_port = 16'h002A;
    #1 chk("t3_ready", 32'(in_ready), 1);
    tick();
    run = 1'b0; in_valid = 1'b0;
    chk("t3_r0", 32'(r0_out), 32'h2A);
    chk("t3_retired", retired, 1);
    #1 chk("t3_ready_cycles", 32'(ir_cnt), 1);

    // 16-bit carry-out to zero, then conditional jump
    for (int i = 0; i < 7; i++) load(i, prog4[i]);
    do_reset();
    run = 1'b1;
    tick(5);
    chk("t4_r1", 32'(r1_out), 32'hFFFF);
    chk("t4_r3", 32'(r3_out), 0);
    tick(2);
    run = 1'b0;
    chk("t4_pc", 32'(pc), 32'h10);

    // PC wrap over straight-line NOPs
    for (int i = 0; i < 7; i++) load(i, 8'h87);
    do_reset();
    run = 1'b1;
    tick(31);
    chk("t5_pc31", 32'(pc), 31);
    tick();
    chk("t5_pc_wrap", 32'(pc), 0);
    chk("t5_retired", retired, 32);
    tick(5);
    run = 1'b0;
    chk("t5_retired2", retired, 37);

    // single step and load-blocked-by-step
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0; tick();
    end
    chk("t6_retired", retired, 3);
    chk("t6_pc", 32'(pc), 3);
    step = 1'b1; prog_we = 1'b1; prog_addr = 5'd4; prog_data = 8'h11;
    tick();
    step = 1'b0; prog_we = 1'b0;
    chk("t6_pc4", 32'(pc), 4);
    chk("t6_ram_kept", 32'(instr_debug), 32'h87);
    load(4, 8'h22);
    chk("t6_ram_write", 32'(instr_debug), 32'h22);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      run       = ($urandom_range(0, 99) < 55);
      step      = !run && ($urandom_range(0, 2) == 0);
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = PW'($urandom);
      prog_data = 8'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_port   = DW'($urandom);
      reset_n   = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1; run = 1'b0; step = 1'b0; prog_we = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
